// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-port bundle for the
// shared instruction/data memory arbiter.
interface mem_port_arbiter_if;
  logic        flush;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst_0;
  logic [31:0] if_resp_inst_1;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_we;
  logic [31:0] lsu_req_wdata;
  logic [2:0]  lsu_req_func3;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_misaligned;

  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  flush,
    input  if_req_valid, if_req_addr,
    output if_req_ready,
    output if_resp_valid, if_resp_inst_0, if_resp_inst_1,
    input  lsu_req_valid, lsu_req_addr, lsu_req_we,
    input  lsu_req_wdata, lsu_req_func3,
    output lsu_req_ready,
    output lsu_resp_valid, lsu_resp_data, lsu_resp_misaligned,
    output mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output flush,
    output if_req_valid, if_req_addr,
    input  if_req_ready,
    input  if_resp_valid, if_resp_inst_0, if_resp_inst_1,
    output lsu_req_valid, lsu_req_addr, lsu_req_we,
    output lsu_req_wdata, lsu_req_func3,
    input  lsu_req_ready,
    input  lsu_resp_valid, lsu_resp_data, lsu_resp_misaligned,
    input  mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/LSU arbiter and access sequencer for a single
// 32-bit memory port: LSU-first with a fetch starvation bound.
module mem_port_arbiter #(
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW =
    (MAX_LSU_STREAK > 0) ? $clog2(MAX_LSU_STREAK + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [2:0] {
    IDLE, IF0, IF1, IF_WAIT, LD, LD_WAIT, ST
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [63:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   first_q, first_d;
  logic [31:0]   inst0_q, inst0_d;
  logic [31:0]   inst1_q, inst1_d;
  logic [31:0]   ldata_q, ldata_d;
  logic          mis_q, mis_d;
  logic          ifv_q, ifv_d;
  logic          lsv_q, lsv_d;

  logic          gnt_if;
  logic          if_rdy, ls_rdy;
  logic          is_b, is_h, is_w, bad;
  logic [63:0]   waddr;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld_ext;
  logic [3:0]    st_strb;
  logic [31:0]   st_wdata;
  logic          m_en, m_we;
  logic [63:0]   m_addr;
  logic [3:0]    m_strb;
  logic [31:0]   m_wdata;

  assign waddr = {addr_q[63:2], 2'b00};
  assign is_b  = (f3_q[1:0] == 2'b00);
  assign is_h  = (f3_q[1:0] == 2'b01);
  assign is_w  = (f3_q == 3'b010);
  assign bad   = (f3_q[1:0] == 2'b11)
               | (f3_q == 3'b110)
               | (is_h & addr_q[0])
               | (is_w & (addr_q[1:0] != 2'b00));

  // Fetch wins a tie only once the LSU streak has hit the bound.
  assign gnt_if = bus.if_req_valid & ~bus.flush
                & (~bus.lsu_req_valid | (streak_q == SMAX));

  assign lb = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign lh = addr_q[1] ? bus.mem_rdata[31:16]
                        : bus.mem_rdata[15:0];

  always_comb begin
    ld_ext = bus.mem_rdata;
    unique case (1'b1)
      is_b:    ld_ext = {{24{lb[7] & ~f3_q[2]}}, lb};
      is_h:    ld_ext = {{16{lh[15] & ~f3_q[2]}}, lh};
      default: ;
    endcase
  end

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = wdata_q;
    unique case (1'b1)
      is_b: begin
        st_strb  = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      is_h: begin
        st_strb  = 4'b0011 << {addr_q[1], 1'b0};
        st_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    first_d  = first_q;
    inst0_d  = inst0_q;
    inst1_d  = inst1_q;
    ldata_d  = ldata_q;
    mis_d    = mis_q;
    ifv_d    = 1'b0;
    lsv_d    = 1'b0;
    if_rdy   = 1'b0;
    ls_rdy   = 1'b0;
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_strb   = '0;
    m_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (!bus.if_req_valid) streak_d = '0;
        if (gnt_if) begin
          if_rdy   = 1'b1;
          addr_d   = bus.if_req_addr;
          streak_d = '0;
          state_d  = IF0;
        end else if (bus.lsu_req_valid) begin
          ls_rdy  = 1'b1;
          addr_d  = bus.lsu_req_addr;
          wdata_d = bus.lsu_req_wdata;
          f3_d    = bus.lsu_req_func3;
          state_d = bus.lsu_req_we ? ST : LD;
          if (bus.if_req_valid && streak_q != SMAX)
            streak_d = streak_q + 1'b1;
        end
      end
      IF0: begin
        m_en    = 1'b1;
        m_addr  = waddr;
        state_d = bus.flush ? IDLE : IF1;
      end
      IF1: begin
        m_en    = 1'b1;
        m_addr  = waddr + 64'd4;
        state_d = bus.flush ? IDLE : IF_WAIT;
        if (!bus.flush) first_d = bus.mem_rdata;
      end
      IF_WAIT: begin
        state_d = IDLE;
        // Both words commit together so a flush leaves them intact.
        if (!bus.flush) begin
          inst0_d = first_q;
          inst1_d = bus.mem_rdata;
          ifv_d   = 1'b1;
        end
      end
      LD: begin
        m_en    = ~bad;
        m_addr  = bad ? '0 : waddr;
        state_d = LD_WAIT;
      end
      LD_WAIT: begin
        state_d = IDLE;
        lsv_d   = 1'b1;
        mis_d   = bad;
        ldata_d = bad ? '0 : ld_ext;
      end
      ST: begin
        if (!bad) begin
          m_en    = 1'b1;
          m_we    = 1'b1;
          m_addr  = waddr;
          m_strb  = st_strb;
          m_wdata = st_wdata;
        end
        state_d = IDLE;
        lsv_d   = 1'b1;
        mis_d   = bad;
        ldata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      first_q  <= '0;
      inst0_q  <= '0;
      inst1_q  <= '0;
      ldata_q  <= '0;
      mis_q    <= 1'b0;
      ifv_q    <= 1'b0;
      lsv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      first_q  <= first_d;
      inst0_q  <= inst0_d;
      inst1_q  <= inst1_d;
      ldata_q  <= ldata_d;
      mis_q    <= mis_d;
      ifv_q    <= ifv_d;
      lsv_q    <= lsv_d;
    end
  end

  assign bus.if_req_ready        = if_rdy;
  assign bus.lsu_req_ready       = ls_rdy;
  assign bus.if_resp_valid       = ifv_q;
  assign bus.if_resp_inst_0      = inst0_q;
  assign bus.if_resp_inst_1      = inst1_q;
  assign bus.lsu_resp_valid      = lsv_q;
  assign bus.lsu_resp_data       = ldata_q;
  assign bus.lsu_resp_misaligned = mis_q;
  assign bus.mem_en              = m_en;
  assign bus.mem_we              = m_we;
  assign bus.mem_addr            = m_addr;
  assign bus.mem_wstrb           = m_strb;
  assign bus.mem_wdata           = m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: behavioural memory,
// reference model queues and directed fetch/LSU/arbiter traffic.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        mis;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [63:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } beat_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_bad;

  logic [31:0] mem_arr [1024];
  logic [31:0] refmem  [1024];
  logic [31:0] rdata;
  logic [31:0] last0, last1;

  exp_t  fq[$];
  exp_t  lq[$];
  beat_t mq[$];
  bit    glog[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_LSU_STREAK(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  assign bus.mem_rdata = rdata;

  always @(posedge clock) begin
    if (bus.mem_en && !bus.mem_we)
      rdata <= mem_arr[bus.mem_addr[11:2]];
    if (bus.mem_en && bus.mem_we)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wstrb[i])
          mem_arr[bus.mem_addr[11:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic lsu_model(input logic [63:0] a,
                           input logic        we,
                           input logic [31:0] wd,
                           input logic [2:0]  f3);
    exp_t        e;
    beat_t       b;
    logic [31:0] w, sh, wv;
    logic [3:0]  st;
    logic        bd;
    w  = refmem[a[11:2]];
    bd = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
      || (f3[1:0] == 2'd1 && a[0])
      || (f3[1:0] == 2'd2 && a[1:0] != 2'b00);
    e.mis = bd;
    e.d0  = 32'h0;
    e.d1  = 32'h0;
    e.cyc = cyc + (we ? 2 : 3);
    if (!bd) begin
      b.cyc   = cyc + 1;
      b.we    = we;
      b.addr  = {a[63:2], 2'b00};
      b.strb  = 4'h0;
      b.wdata = 32'h0;
      if (we) begin
        case (f3[1:0])
          2'd0: begin st = 4'b0001 << a[1:0]; wv = wd[7:0] * 32'h01010101; end
          2'd1: begin st = a[1] ? 4'b1100 : 4'b0011; wv = wd[15:0] * 32'h00010001; end
          default: begin st = 4'b1111; wv = wd; end
        endcase
        b.strb  = st;
        b.wdata = wv;
        for (int i = 0; i < 4; i++)
          if (st[i]) w[8*i +: 8] = wv[8*i +: 8];
        refmem[a[11:2]] = w;
      end else begin
        sh = w >> (8 * a[1:0]);
        case (f3)
          3'b000:  e.d0 = 32'($signed(sh[7:0]));
          3'b100:  e.d0 = sh & 32'hFF;
          3'b001:  e.d0 = 32'($signed(sh[15:0]));
          3'b101:  e.d0 = sh & 32'hFFFF;
          default: e.d0 = w;
        endcase
      end
      mq.push_back(b);
    end
    lq.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t        e;
    beat_t       b;
    logic [63:0] a;
    chk("one_ready", bus.if_req_ready & bus.lsu_req_ready, 0);
    if (bus.if_req_valid && bus.if_req_ready) begin
      a     = bus.if_req_addr & ~64'h3;
      e.d0  = refmem[a[11:2]];
      b.cyc = cyc + 1; b.we = 0; b.addr = a; b.strb = 0; b.wdata = 0;
      mq.push_back(b);
      a     = a + 64'd4;
      e.d1  = refmem[a[11:2]];
      b.cyc = cyc + 2; b.addr = a;
      mq.push_back(b);
      e.mis = 0;
      e.cyc = cyc + 4;
      fq.push_back(e);
      glog.push_back(1'b1);
    end
    if (bus.lsu_req_valid && bus.lsu_req_ready) begin
      lsu_model(bus.lsu_req_addr, bus.lsu_req_we,
                bus.lsu_req_wdata, bus.lsu_req_func3);
      glog.push_back(1'b0);
    end
    if (bus.if_resp_valid) begin
      chk("if_expected", fq.size() > 0, 1);
      if (fq.size() > 0) begin
        e = fq.pop_front();
        chk("inst0", bus.if_resp_inst_0, e.d0);
        chk("inst1", bus.if_resp_inst_1, e.d1);
        chk("if_lat", cyc, e.cyc);
        last0 = e.d0;
        last1 = e.d1;
      end
    end
    if (bus.lsu_resp_valid) begin
      chk("lsu_expected", lq.size() > 0, 1);
      if (lq.size() > 0) begin
        e = lq.pop_front();
        chk("lsu_data", bus.lsu_resp_data, e.d0);
        chk("lsu_mis", bus.lsu_resp_misaligned, e.mis);
        chk("lsu_lat", cyc, e.cyc);
      end
    end
    if (bus.mem_en) begin
      chk("mem_expected", mq.size() > 0, 1);
      if (mq.size() > 0) begin
        b = mq.pop_front();
        chk("mem_cyc", cyc, b.cyc);
        chk("mem_addr", bus.mem_addr, b.addr);
        chk("mem_we", bus.mem_we, b.we);
        chk("mem_wstrb", bus.mem_wstrb, b.strb);
        chk("mem_wdata", bus.mem_wdata, b.wdata);
      end
    end else begin
      chk("mem_idle", |{bus.mem_we, bus.mem_wstrb,
                        bus.mem_wdata, bus.mem_addr}, 0);
      if (mq.size() > 0 && mq[0].cyc <= cyc) begin
        chk("mem_missing", bus.mem_en, 1);
        void'(mq.pop_front());
      end
    end
  end

  task automatic wait_grant(input bit is_if);
    int n = 0;
    forever begin
      @(negedge clock);
      if (is_if ? bus.if_req_ready : bus.lsu_req_ready) break;
      if (++n > 100) begin
        chk("grant_timeout", is_if ? bus.if_req_ready : bus.lsu_req_ready, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
    if (is_if) bus.if_req_valid = 1'b0;
    else       bus.lsu_req_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [63:0] a);
    bus.if_req_addr  = a;
    bus.if_req_valid = 1'b1;
    wait_grant(1'b1);
  endtask

  task automatic do_lsu(input logic [63:0] a, input logic we,
                        input logic [31:0] wd, input logic [2:0] f3);
    bus.lsu_req_addr  = a;
    bus.lsu_req_we    = we;
    bus.lsu_req_wdata = wd;
    bus.lsu_req_func3 = f3;
    bus.lsu_req_valid = 1'b1;
    wait_grant(1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((fq.size() + lq.size()) != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    chk("drain", fq.size() + lq.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_g [6];
    int n;
    n_chk = 0;
    n_bad = 0;
    last0 = 0;
    last1 = 0;
    rdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = 32'(i) * 32'h9E3779B1;
      refmem[i]  = mem_arr[i];
    end
    mem_arr[32'h100 >> 2] = 32'h00500093; refmem[32'h100 >> 2] = 32'h00500093;
    mem_arr[32'h104 >> 2] = 32'h00a00113; refmem[32'h104 >> 2] = 32'h00a00113;
    mem_arr[32'h108 >> 2] = 32'h11111111; refmem[32'h108 >> 2] = 32'h11111111;
    mem_arr[32'h10C >> 2] = 32'h22222222; refmem[32'h10C >> 2] = 32'h22222222;
    mem_arr[32'h200 >> 2] = 32'h80FF1234; refmem[32'h200 >> 2] = 32'h80FF1234;
    mem_arr[32'h300 >> 2] = 32'h00000000; refmem[32'h300 >> 2] = 32'h00000000;
    bus.flush         = 0;
    bus.if_req_valid  = 0;
    bus.if_req_addr   = 0;
    bus.lsu_req_valid = 0;
    bus.lsu_req_addr  = 0;
    bus.lsu_req_we    = 0;
    bus.lsu_req_wdata = 0;
    bus.lsu_req_func3 = 0;
    reset = 0;
    #22 reset = 1;

    @(negedge clock);
    chk("rst_inst0", bus.if_resp_inst_0, 0);
    chk("rst_inst1", bus.if_resp_inst_1, 0);
    chk("rst_ldata", bus.lsu_resp_data, 0);
    chk("rst_valids", {bus.if_resp_valid, bus.lsu_resp_valid,
                       bus.lsu_resp_misaligned, bus.mem_en}, 0);
    chk("rst_ready", {bus.if_req_ready, bus.lsu_req_ready}, 0);
    @(posedge clock); #1;

    do_fetch(64'h100);
    drain();

    do_lsu(64'h203, 0, 0, 3'b000);
    do_lsu(64'h202, 0, 0, 3'b101);
    do_lsu(64'h200, 0, 0, 3'b001);
    do_lsu(64'h202, 0, 0, 3'b001);
    do_lsu(64'h201, 0, 0, 3'b100);
    do_lsu(64'h200, 0, 0, 3'b010);
    drain();

    do_lsu(64'h301, 1, 32'h000000AB, 3'b000);
    do_lsu(64'h302, 1, 32'hDEADBEEF, 3'b010);
    do_lsu(64'h302, 1, 32'h55553333, 3'b001);
    do_lsu(64'h304, 1, 32'h12345678, 3'b010);
    do_lsu(64'h300, 0, 0, 3'b010);
    do_lsu(64'h301, 0, 0, 3'b001);
    do_lsu(64'h300, 0, 0, 3'b011);
    do_lsu(64'h300, 1, 32'hFFFFFFFF, 3'b110);
    do_lsu(64'h304, 0, 0, 3'b010);
    drain();

    do_fetch(64'h103);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    drain();

    glog.delete();
    bus.if_req_addr   = 64'h100;
    bus.lsu_req_addr  = 64'h200;
    bus.lsu_req_we    = 0;
    bus.lsu_req_func3 = 3'b010;
    bus.if_req_valid  = 1;
    bus.lsu_req_valid = 1;
    n = 0;
    while (glog.size() < 6 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    bus.if_req_valid  = 0;
    bus.lsu_req_valid = 0;
    exp_g = '{0, 0, 0, 0, 1, 0};
    chk("arb_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk($sformatf("arb_%0d", i), glog[i], exp_g[i]);
    drain();

    do_fetch(64'h108);
    @(posedge clock); #1;
    bus.flush = 1;
    void'(fq.pop_back());
    @(posedge clock); #1;
    bus.flush = 0;
    chk("flush_inst0", bus.if_resp_inst_0, last0);
    chk("flush_inst1", bus.if_resp_inst_1, last1);
    bus.if_req_addr  = 64'h100;
    bus.if_req_valid = 1;
    @(negedge clock);
    chk("flush_idle", bus.if_req_ready, 1);
    @(posedge clock); #1;
    bus.if_req_valid = 0;
    drain();

    bus.flush        = 1;
    bus.if_req_addr  = 64'h108;
    bus.if_req_valid = 1;
    repeat (3) begin
      @(negedge clock);
      chk("flush_rdy", bus.if_req_ready, 0);
    end
    @(posedge clock); #1;
    bus.if_req_valid = 0;
    bus.flush        = 0;
    drain();

    do_lsu(64'h200, 0, 0, 3'b010);
    @(posedge clock); #2;
    reset = 0;
    #1;
    chk("rst_mid_valid", {bus.if_resp_valid, bus.lsu_resp_valid,
                          bus.lsu_resp_misaligned}, 0);
    chk("rst_mid_data", bus.lsu_resp_data, 0);
    chk("rst_mid_inst", {bus.if_resp_inst_0, bus.if_resp_inst_1}, 0);
    chk("rst_mid_mem", {bus.mem_en, bus.mem_we, bus.mem_wstrb,
                        bus.mem_wdata}, 0);
    chk("rst_mid_addr", bus.mem_addr, 0);
    lq.delete();
    mq.delete();
    last0 = 0;
    last1 = 0;
    #10 reset = 1;
    @(posedge clock); #1;
    do_lsu(64'h203, 0, 0, 3'b000);
    do_fetch(64'h100);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter placed in front of the single-ported 32-bit instruction/data memory. It serves two requesters: the fetch stage, which needs two consecutive instructions per request, and the LSU, which issues byte, half and word loads and stores. The block runs the multi-beat memory accesses and generates byte strobes and load extension from `func3`. It uses LSU-first priority with a starvation bound for fetch.

## Interface
Parameters:
- `MAX_LSU_STREAK`, default 4: the maximum number of consecutive LSU grants while fetch is waiting.

Ports:
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous pipeline redirect. It aborts an in-progress fetch.
- `if_req_valid`, in, 1, and `if_req_ready`, out, 1: fetch request handshake.
- `if_req_addr`, in, 64: fetch address. Bits [1:0] are ignored.
- `if_resp_valid`, out, 1: one-cycle pulse marking a fetch response.
- `if_resp_inst_0`, out, 32, and `if_resp_inst_1`, out, 32: instructions at addr and addr+4.
- `lsu_req_valid`, in, 1, and `lsu_req_ready`, out, 1: LSU request handshake.
- `lsu_req_addr`, in, 64: byte address.
- `lsu_req_we`, in, 1: 1 for a store.
- `lsu_req_wdata`, in, 32: store data, LSB-aligned.
- `lsu_req_func3`, in, 3: RV32I funct3.
- `lsu_resp_valid`, out, 1: one-cycle pulse marking an LSU response.
- `lsu_resp_data`, out, 32: extended load data; 0 for stores.
- `lsu_resp_misaligned`, out, 1: marks an access that was not performed.
- `mem_en`, out, 1, and `mem_we`, out, 1: memory access strobe and write enable.
- `mem_addr`, out, 64: word-aligned; bits [1:0] are always 0.
- `mem_wstrb`, out, 4, and `mem_wdata`, out, 32: byte strobes and write data.
- `mem_rdata`, in, 32: valid in the cycle after a read with `mem_en=1`, `mem_we=0`.

## Operation
FSM states: IDLE, IF0, IF1, IF_WAIT, LD, LD_WAIT, ST.

Handshake and arbitration:
- `if_req_ready` and `lsu_req_ready` can only be 1 in IDLE, and at most one is 1 in any cycle.
- A request is accepted on a rising edge where its valid and ready are both 1. The block latches addr, we, wdata and func3 at that edge.
- If only one requester is valid, that requester gets ready.
- If both are valid, LSU wins unless `streak == MAX_LSU_STREAK`, in which case fetch wins.
- `streak` increments, saturating, on an LSU grant while `if_req_valid=1`. It clears on a fetch grant, and in any IDLE cycle with `if_req_valid=0`.
- While `flush=1`, `if_req_ready=0`. The LSU may still be granted in that cycle.

Fetch path:
- IF0 reads `{addr[63:2],2'b00}`.
- IF1 reads that address +4, wrapping modulo 2^64, and captures `mem_rdata` into inst_0.
- IF_WAIT captures `mem_rdata` into inst_1. The next state is IDLE, with `if_resp_valid=1` for that one cycle.
- `flush=1` in IF0, IF1 or IF_WAIT sends the FSM to IDLE at the next edge. No response is issued and the inst registers are not updated.

Load path:
- LD reads the word address. LD_WAIT extracts from `mem_rdata`:
  - `func3=000` LB: byte at `addr[1:0]`, sign-extended.
  - `100` LBU: byte, zero-extended.
  - `001` LH: half at `addr[1]`, sign-extended.
  - `101` LHU: half, zero-extended.
  - `010` LW: the whole word.
- The next state is IDLE, with `lsu_resp_valid=1`.

Store path:
- ST drives `mem_en=1`, `mem_we=1` and the strobes below. The next state is IDLE, with `lsu_resp_valid=1` and `lsu_resp_data=0`.
- `000` SB: wstrb `4'b0001<<addr[1:0]`, wdata replicates the byte 4 times.
- `001` SH: wstrb `4'b0011<<{addr[1],1'b0}`, wdata replicates the half twice.
- `010` SW: wstrb `4'b1111`.

Misaligned or illegal LSU access:
- Covers half access with `addr[0]=1`, word access with `addr[1:0]!=0`, and `func3` in {011,110,111}.
- The FSM still passes through LD/LD_WAIT or ST, but `mem_en=0`.
- The response has `lsu_resp_data=0` and `lsu_resp_misaligned=1`.

Flush has no effect on LSU transactions.

## Timing
Reset values: state IDLE, `streak=0`. All of `if_resp_valid`, `lsu_resp_valid`, `lsu_resp_misaligned`, `mem_en`, `mem_we`, `mem_wstrb`, `mem_wdata`, `mem_addr`, both inst registers and `lsu_resp_data` are 0. Reset takes effect immediately, including mid-transaction; no response is produced for an interrupted access.

Accept edge at the end of cycle A:
- Fetch: memory reads in A+1 and A+2, `if_resp_valid` in A+4.
- Load: memory read in A+1, `lsu_resp_valid` in A+3.
- Store: memory write in A+1, `lsu_resp_valid` in A+2.

Response and back-to-back behaviour:
- Response data and inst registers hold their value until the next response of the same kind overwrites them.
- The response cycle is an IDLE cycle, so the next accept can occur in it.
- Back-to-back throughput: one fetch per 4 cycles, one load per 3 cycles, one store per 2 cycles.

`mem_*` outputs are 0 in every state that does not access memory.

## Test plan
1. Fetch at 0x100, memory word 0x100=0x00500093, 0x104=0x00a00113 -> `if_resp_valid` in A+4 with inst_0=0x00500093, inst_1=0x00a00113; `mem_addr` 0x100 then 0x104.
2. Load LB from 0x203 with word 0x80FF_1234 -> `lsu_resp_data=0xFFFFFF80` in A+3. LHU from 0x202 on the same word -> `0x000080FF`.
3. Store SB 0xAB to 0x301 -> `mem_wstrb=4'b0010`, `mem_wdata=0xABABABAB`, `lsu_resp_valid` in A+2. Store SW to 0x302 -> `mem_en=0`, `lsu_resp_misaligned=1`.
4. Both requesters held valid continuously with MAX_LSU_STREAK=4 -> grant order LSU, LSU, LSU, LSU, IF, then LSU again.
5. Flush in IF1 -> no `if_resp_valid`, inst registers unchanged, FSM in IDLE next cycle. `flush` held in IDLE with only fetch valid -> `if_req_ready=0`.
6. `reset` asserted during LD_WAIT -> all outputs 0 immediately, no `lsu_resp_valid`. After release, a new load completes normally.
